instr_fetch_stage: RTL
======================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage directly downstream of the program counter register.
//  Consumes PC_CNT, issues one instruction-memory read at a time, and computes PC_DIN/pc_write back into the PC.
//  Holds the IF/ID pipeline register with a valid/ready handshake toward decode.
//  Absorbs variable memory latency, decode stalls and branch/jump redirects (flush).
// PARAMETERS
//  NOP_INSTR  32'h00000013  IF_INSTR value after reset/flush (addi x0,x0,0)
//  PC_STEP    4             sequential PC increment, bytes
// PORTS
//  if_clk          in   1   clock; all state updates on rising edge
//  if_rst          in   1   synchronous reset, active-high
//  PC_CNT          in   32  current PC from program counter register
//  PC_DIN          out  32  next PC value to program counter
//  pc_write        out  1   program counter write enable
//  redirect_valid  in   1   branch/jump taken in later stage; flush fetch
//  redirect_addr   in   32  redirect target
//  imem_req        out  1   instruction read request
//  imem_addr       out  32  read address (= PC_CNT)
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   read data valid (>=1 cycle after gnt)
//  imem_rdata      in   32  instruction word
//  if_valid        out  1   IF/ID register holds a valid instruction
//  id_ready        in   1   decode accepts IF/ID this cycle
//  IF_INSTR        out  32  fetched instruction
//  IF_PC           out  32  PC of IF_INSTR
//  IF_PC4          out  32  IF_PC + PC_STEP
// BEHAVIOUR
//  Reset (if_rst=1 at edge): state=REQ, kill=0, if_valid=0, IF_INSTR=NOP_INSTR, IF_PC=0, IF_PC4=0, hold buffer empty.
//  - pc_write, PC_DIN and imem_req are combinational.
//  - During the reset cycle: pc_write=0, imem_req=0.
//  Max one outstanding read. Per-request tag = PC latched at grant.
//  States:
//  - REQ: imem_req=1 iff (!if_valid || id_ready) and !redirect_valid; on gnt -> WAIT.
//  - WAIT: imem_req=0; on rvalid: if kill -> REQ (data dropped, kill cleared).
//    Else if slot free (!if_valid || id_ready) -> load IF/ID, -> REQ.
//    Else -> HOLD (data+tag to hold buffer).
//  - HOLD: imem_req=0; when id_ready -> move hold buffer into IF/ID, -> REQ.
//  Slot free check uses registered if_valid and this-cycle id_ready (load and drain same edge allowed).
//  Handshake to decode: transfer when if_valid && id_ready. if_valid && !id_ready holds IF_* stable.
//  PC update:
//  - redirect_valid: pc_write=1, PC_DIN={redirect_addr[31:2],2'b00}; highest priority.
//  - else imem_req && imem_gnt: pc_write=1, PC_DIN=PC_CNT+PC_STEP, mod 2^32 (0xFFFFFFFC -> 0x00000000).
//  - else pc_write=0, PC_DIN=PC_CNT.
//  Redirect (any state), next edge:
//  - if_valid=0, IF_INSTR=NOP_INSTR, hold buffer cleared.
//  - In WAIT, or grant in same cycle: kill=1, state=WAIT.
//  - In HOLD: state=REQ.
//  - Redirect with rvalid same cycle: response dropped.
//  - Redirect with id_ready same cycle: transfer to decode still counts; register then flushes.
//  Redirect priority: redirect beats rvalid load and beats id_ready refill.
//  imem_rvalid outside WAIT is ignored.
//  Reset mid-WAIT: outstanding response discarded; memory side is reset on the same if_rst.
//  IF_PC4 = IF_PC + PC_STEP, mod 2^32.
// TESTING
//  1. Zero-latency memory (rvalid 1 cycle after gnt), id_ready=1.
//     -> PC 0,4,8,C fetched; one instr/2 cycles; IF_PC tracks; pc_write pulses at grants.
//  2. id_ready=0 with IF/ID full, rvalid arrives.
//     -> state HOLD, imem_req=0, IF_* stable; id_ready=1 -> hold data appears next edge.
//  3. Redirect to 0x0000_0103 while WAIT.
//     -> PC_DIN=0x100, pc_write=1; late rvalid dropped; next fetch at 0x100 with if_valid=1.
//  4. Redirect same cycle as gnt for PC=0x20.
//     -> 0x20 response dropped; no IF_PC=0x20 ever valid; next IF_PC=target.
//  5. PC_CNT=0xFFFFFFFC granted.
//     -> PC_DIN=0x00000000; IF_PC4=0x00000000 when that instr lands.
//  6. if_rst asserted in WAIT.
//     -> next cycle if_valid=0, IF_INSTR=0x00000013, imem_req=0; then REQ from PC 0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage
// Brief    : Fetch stage issuing one instruction-memory read at a time and
//            driving the IF/ID register toward decode.
// Revision : 1.0
// ============================================================================
module instr_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic        if_clk,
  input  logic        if_rst,
  input  logic [31:0] PC_CNT,
  output logic [31:0] PC_DIN,
  output logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4
);

  localparam logic [31:0] c_step = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q;
  logic        kill_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] tag_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc_q;

  logic        w_slot_free;
  logic        w_grant;
  logic        w_unused_addr_lsb;

  // Slot is free when IF/ID is empty or being drained by decode this cycle.
  assign w_slot_free = !valid_q || id_ready;
  assign imem_req    = !if_rst && (state_q == S_REQ) && w_slot_free && !redirect_valid;
  assign w_grant     = imem_req && imem_gnt;
  assign imem_addr   = PC_CNT;

  always_comb begin
    pc_write = 1'b0;
    PC_DIN   = PC_CNT;
    if (!if_rst) begin
      if (redirect_valid) begin
        pc_write = 1'b1;
        PC_DIN   = {redirect_addr[31:2], 2'b00};
      end else if (w_grant) begin
        pc_write = 1'b1;
        PC_DIN   = PC_CNT + c_step;
      end
    end
  end

  assign w_unused_addr_lsb = ^redirect_addr[1:0];

  always_ff @(posedge if_clk) begin
    if (if_rst) begin
      state_q      <= S_REQ;
      kill_q       <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= 32'd0;
      pc4_q        <= 32'd0;
      tag_q        <= 32'd0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'd0;
    end else begin
      if (valid_q && id_ready) begin
        valid_q <= 1'b0;
      end
      if (redirect_valid) begin
        valid_q      <= 1'b0;
        instr_q      <= NOP_INSTR;
        hold_instr_q <= NOP_INSTR;
        hold_pc_q    <= 32'd0;
        // A response arriving with the redirect retires the outstanding read.
        if ((state_q == S_WAIT) && !imem_rvalid) begin
          state_q <= S_WAIT;
          kill_q  <= 1'b1;
        end else begin
          state_q <= S_REQ;
          kill_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          S_REQ: begin
            if (w_grant) begin
              tag_q   <= PC_CNT;
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (kill_q) begin
                kill_q  <= 1'b0;
                state_q <= S_REQ;
              end else if (w_slot_free) begin
                valid_q <= 1'b1;
                instr_q <= imem_rdata;
                pc_q    <= tag_q;
                pc4_q   <= tag_q + c_step;
                state_q <= S_REQ;
              end else begin
                hold_instr_q <= imem_rdata;
                hold_pc_q    <= tag_q;
                state_q      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (id_ready) begin
              valid_q <= 1'b1;
              instr_q <= hold_instr_q;
              pc_q    <= hold_pc_q;
              pc4_q   <= hold_pc_q + c_step;
              state_q <= S_REQ;
            end
          end
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

  assign if_valid = valid_q;
  assign IF_INSTR = instr_q;
  assign IF_PC    = pc_q;
  assign IF_PC4   = pc4_q;

endmodule
`default_nettype wire
